// File: rtl/mul_pipe_ctrl.sv
// mul_pipe_ctrl: handshake and sequencing controller for the two-stage
// Booth/Wallace multiplier. S0 holds the extended operands and drives the
// datapath. S1 is the datapath tree register plus this block's op/tag copy.
// OUT is a one-entry result buffer. Every stage can advance in the same
// cycle, so a new operation can complete every clock.
module mul_pipe_ctrl #(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       req_src1,
    input  logic [31:0]       req_src2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [32:0]       dp_x,
    output logic [32:0]       dp_y,
    output logic              dp_s1_en,
    input  logic [63:0]       dp_prod,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_result,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [31:0]       mul_cnt
);

    // Operation encodings. Code 11 behaves as MUL_W.
    localparam logic [1:0] OP_MUL_W    = 2'b00;
    localparam logic [1:0] OP_MULH_W   = 2'b01;
    localparam logic [1:0] OP_MULH_WU  = 2'b10;
    localparam logic [1:0] OP_MUL_ALT  = 2'b11;

    // Stage valid bits.
    logic             v0_reg;
    logic             v1_reg;
    logic             v2_reg;

    // Per-stage op/tag payload travelling beside the datapath.
    logic [1:0]       op0_reg;
    logic [TAG_W-1:0] tag0_reg;
    logic [1:0]       op1_reg;
    logic [TAG_W-1:0] tag1_reg;

    // Operand and output-buffer registers.
    logic [32:0]      dp_x_reg;
    logic [32:0]      dp_y_reg;
    logic [31:0]      result_reg;
    logic [TAG_W-1:0] rtag_reg;
    logic [31:0]      mul_cnt_reg;

    // Advance controls, derived only from registered valid bits and resp_ready.
    logic             out_free;
    logic             s1_mv;
    logic             s0_mv;
    logic             accept;
    logic             resp_fire;
    logic [32:0]      ext_x;
    logic [32:0]      ext_y;
    logic [31:0]      half_sel;

    // Operand extension: only the unsigned-high form zero-extends. MUL_W and
    // the alias code use sign extension, which leaves the low word unchanged.
    function automatic logic [32:0] extend(input logic [1:0] op, input logic [31:0] src);
        logic [32:0] res;
        if (op == OP_MULH_WU) begin
            res = {1'b0, src};
        end else begin
            res = {src[31], src};
        end
        return res;
    endfunction

    // Pipeline advance logic: a stage moves when the stage after it is empty
    // or is moving out in the same cycle.
    always_comb begin
        out_free  = !v2_reg | resp_ready;
        s1_mv     = v1_reg & out_free;
        s0_mv     = v0_reg & (!v1_reg | s1_mv);
        req_ready = (!v0_reg | s0_mv) & !flush;
        accept    = req_valid & req_ready;
        resp_fire = v2_reg & resp_ready;
        ext_x     = extend(req_op, req_src1);
        ext_y     = extend(req_op, req_src2);
    end

    // Select the product half returned for the op currently held in S1.
    always_comb begin
        half_sel = dp_prod[31:0];
        case (op1_reg)
            OP_MULH_W, OP_MULH_WU: half_sel = dp_prod[63:32];
            OP_MUL_W, OP_MUL_ALT:  half_sel = dp_prod[31:0];
            default:               half_sel = dp_prod[31:0];
        endcase
    end

    // Valid bits: flush empties every stage. Otherwise each bit is set by a
    // move into its stage and cleared by a move out that is not refilled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v0_reg <= 1'b0;
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
        end else if (flush) begin
            v0_reg <= 1'b0;
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
        end else begin
            if (accept) begin
                v0_reg <= 1'b1;
            end else if (s0_mv) begin
                v0_reg <= 1'b0;
            end

            if (s0_mv) begin
                v1_reg <= 1'b1;
            end else if (s1_mv) begin
                v1_reg <= 1'b0;
            end

            if (s1_mv) begin
                v2_reg <= 1'b1;
            end else if (resp_fire) begin
                v2_reg <= 1'b0;
            end
        end
    end

    // S0 payload: the operands stay put until the next accepted request, so
    // the datapath tree sees stable inputs while S0 waits for S1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dp_x_reg <= '0;
            dp_y_reg <= '0;
            op0_reg  <= OP_MUL_W;
            tag0_reg <= '0;
        end else if (accept) begin
            dp_x_reg <= ext_x;
            dp_y_reg <= ext_y;
            op0_reg  <= req_op;
            tag0_reg <= req_tag;
        end
    end

    // S1 payload: follows the tree register, which loads on the same enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op1_reg  <= OP_MUL_W;
            tag1_reg <= '0;
        end else if (s0_mv) begin
            op1_reg  <= op0_reg;
            tag1_reg <= tag0_reg;
        end
    end

    // Output buffer: loads only when S1 moves out, so a stalled result and
    // tag stay stable under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_reg <= '0;
            rtag_reg   <= '0;
        end else if (s1_mv) begin
            result_reg <= half_sel;
            rtag_reg   <= tag1_reg;
        end
    end

    // Completed-operation counter. A handshake during a flush cycle still
    // counts because that response has already been delivered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_cnt_reg <= '0;
        end else if (resp_fire) begin
            mul_cnt_reg <= mul_cnt_reg + 32'd1;
        end
    end

    assign dp_x        = dp_x_reg;
    assign dp_y        = dp_y_reg;
    assign dp_s1_en    = s0_mv;
    assign resp_valid  = v2_reg;
    assign resp_result = result_reg;
    assign resp_tag    = rtag_reg;
    assign mul_cnt     = mul_cnt_reg;

endmodule

// File: doc/mul_pipe_ctrl.md
Name: mul_pipe_ctrl

Overview:
- Controller for the two-stage Booth/Wallace multiplier datapath in the EXE/MEM path of myCPU.
- Accepts multiply requests from EXE over a valid/ready handshake and drives sign- or zero-extended 33-bit operands into the datapath.
- Sequences the datapath's stage-1 register enable and captures the 64-bit product into a one-entry output buffer.
- Returns the selected 32-bit half with the request's tag, supports full backpressure and pipeline flush, and keeps a completed-operation counter.

Parameters:
- TAG_W, 4: width of the request tag carried alongside each operation.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill all in-flight operations (exception/branch flush)
- req_valid  in  1  EXE presents a multiply request
- req_ready  out  1  controller accepts the request this cycle
- req_op  in  2  00 MUL_W (low word), 01 MULH_W (signed high), 10 MULH_WU (unsigned high), 11 treated as MUL_W
- req_src1  in  32  multiplicand
- req_src2  in  32  multiplier
- req_tag  in  TAG_W  opaque tag, returned with the result
- dp_x  out  33  registered multiplicand to the datapath: sign-extended for op 00/01, zero-extended for op 10
- dp_y  out  33  registered multiplier, same extension rule
- dp_s1_en  out  1  enable for the datapath's internal tree-output register
- dp_prod  in  64  datapath final-adder output; valid while s1_valid
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_result  out  32  selected product half
- resp_tag  out  TAG_W  tag of the returned operation
- mul_cnt  out  32  number of completed responses (handshakes)

Behaviour:
- Stages:
  - S0 holds the operand registers (dp_x, dp_y), op and tag; valid bit v0.
  - S1 is the datapath tree register plus the controller's op/tag copy; valid bit v1.
  - OUT is the output buffer; valid bit v2, which drives resp_valid.
- Reset (resetn=0, asynchronous): v0=v1=v2=0 and mul_cnt=0. dp_x, dp_y, resp_result and resp_tag reset to 0. req_ready resets to 1 while flush=0.
- Advance rules (combinational from the registered valid bits):
  - out_free = !v2 | resp_ready
  - s1_mv = v1 & out_free
  - s0_mv = v0 & (!v1 | s1_mv)
  - req_ready = (!v0 | s0_mv) & !flush
  - dp_s1_en = s0_mv
- Clock-edge updates:
  - On accept (req_valid & req_ready): load S0; v0=1.
  - On s0_mv without a new accept: v0=0.
  - On s0_mv: S1 op/tag take S0's; v1=1. On s1_mv without s0_mv: v1=0.
  - On s1_mv, OUT captures the product half and S1's tag; v2=1:
    - op 00 or 11: dp_prod[31:0]
    - op 01 or 10: dp_prod[63:32]
  - On resp_valid & resp_ready without s1_mv: v2=0.
- Latency: a request accepted at the edge ending cycle T gives resp_valid=1 in cycle T+3 when no stall occurs. Throughput is one operation per cycle.
- Backpressure: while resp_valid=1 and resp_ready=0, resp_result and resp_tag are held stable and the pipeline fills. At most 3 operations are in flight; req_ready drops only when all three stages are full and stalled.
- dp_x and dp_y change only on an accept. dp_prod is sampled only when s1_mv=1.
- Flush (synchronous, priority over everything except reset):
  - Next edge: v0=v1=v2=0.
  - A request presented during flush is not accepted (req_ready=0).
  - A response handshake in the flush cycle still counts in mul_cnt.
- mul_cnt increments by 1 on each resp_valid & resp_ready and wraps from 0xFFFFFFFF to 0.
- Simultaneous events are legal in the same cycle: accept, S0→S1, S1→OUT and OUT drain all occur together at full throughput.

Test Plan:
- Reset and single ops:
  - Assert resetn=0 mid-operation with v0=v1=v2=1 → all valids=0, mul_cnt=0 and req_ready=1 immediately.
  - After release, send one op, src1=0xFFFFFFFF, src2=0x00000002, tag=3, resp_ready=1. Expected results at T+3:
    - op 00 → 0xFFFFFFFE
    - op 01 → 0xFFFFFFFF
    - op 10 → 0x00000001
  - resp_tag=3 in each case.
- Streaming: issue 8 back-to-back ops 0x00010000×0x00010000 with op 01 and tags 0..7, resp_ready=1 → 8 responses of 0x00000001 on consecutive cycles, tags 0..7 in order, mul_cnt=8.
- Backpressure: hold resp_ready=0 for 6 cycles while streaming → req_ready=0 after 3 accepts, resp_result stable. Release → remaining results in order, none lost or duplicated.
- Flush: flush with 3 ops in flight and req_valid=1 in the same cycle → no response for any of the 4 ops. The next request after flush returns a correct result at T+3.
- Counter wrap: preload mul_cnt via 2^32-1 handshakes (or a forced value) → one more handshake gives mul_cnt=0.
